// File: rtl/gatekeeper_pkg.sv
// Shared definitions for the command gatekeeper: FSM state encoding,
// the default forbidden command word and the requester-index width helper.
package gatekeeper_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        BLOCK = 2'd2
    } gk_state_e;

    // Command word that must never be forwarded downstream.
    localparam logic [31:0] GK_FORBIDDEN_DEFAULT = 32'hdeadbeef;

    // Width of a requester index; never narrower than one bit.
    function automatic int gk_id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: grants the first requester found after the pointer,
// wrapping modulo NREQ. Purely combinational; the pointer lives in the parent.
module rr_arbiter
    import gatekeeper_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = gk_id_w(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   gnt_idx_o,
    output logic            any_o
);

    // Search ptr+1, ptr+2, ... ptr+NREQ so the last winner has lowest priority.
    always_comb begin
        int idx;
        idx       = 0;
        gnt_o     = '0;
        gnt_idx_o = '0;
        any_o     = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(ptr_i) + i) % NREQ;
            if (!any_o && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = IW'(idx);
                any_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/command_gatekeeper.sv
// Command gatekeeper: round-robin shares one downstream command port among
// NREQ requesters and acts as a safety interlock. FORBIDDEN commands are
// dropped, flagged and counted as strikes; after LOCKOUT strikes a requester
// is locked out (its strobes are accepted and discarded) until reset.
module command_gatekeeper
    import gatekeeper_pkg::*;
#(
    parameter int            NREQ      = 4,
    parameter int            DW        = 32,
    parameter logic [DW-1:0] FORBIDDEN = DW'(GK_FORBIDDEN_DEFAULT),
    parameter int            LOCKOUT   = 3
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic [NREQ-1:0]          i_req_stb,
    input  logic [NREQ*DW-1:0]       i_req_data,
    output logic [NREQ-1:0]          o_req_busy,
    output logic                     o_cmd_stb,
    output logic [DW-1:0]            o_cmd_data,
    input  logic                     i_cmd_busy,
    output logic                     o_blocked,
    output logic [gk_id_w(NREQ)-1:0] o_blocked_id,
    output logic [NREQ-1:0]          o_lockout
);

    localparam int            IW         = gk_id_w(NREQ);
    localparam int            SW         = $clog2(LOCKOUT + 1);
    localparam logic [SW-1:0] STRIKE_MAX = SW'(LOCKOUT);

    gk_state_e         state_q;
    logic [IW-1:0]     ptr_q;
    logic              cmd_stb_q;
    logic [DW-1:0]     cmd_data_q;
    logic              blocked_q;
    logic [IW-1:0]     blocked_id_q;
    logic [NREQ-1:0]   lockout_q;
    logic [SW-1:0]     strike_q [NREQ];
    logic [SW-1:0]     strike_d;

    logic [NREQ-1:0]   eligible;
    logic [NREQ-1:0]   gnt;
    logic [IW-1:0]     gnt_idx;
    logic              gnt_any;
    logic [DW-1:0]     sel_data;

    assign eligible = i_req_stb & ~lockout_q;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req_i     (eligible),
        .ptr_i     (ptr_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .any_o     (gnt_any)
    );

    assign sel_data = i_req_data[int'(gnt_idx)*DW +: DW];

    // Strike count for the requester being penalised, saturating at LOCKOUT.
    always_comb begin
        strike_d = strike_q[blocked_id_q];
        if (strike_q[blocked_id_q] != STRIKE_MAX) begin
            strike_d = strike_q[blocked_id_q] + SW'(1);
        end
    end

    // Stall everyone except the granted requester (in IDLE) and locked-out
    // requesters, whose strobes are always swallowed so they never deadlock.
    always_comb begin
        o_req_busy = ~lockout_q;
        if (state_q == IDLE) begin
            o_req_busy = ~(gnt | lockout_q);
        end
    end

    // Control FSM with registered outputs, strike counters and lockout flags.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= IDLE;
            ptr_q        <= IW'(NREQ - 1);
            cmd_stb_q    <= 1'b0;
            cmd_data_q   <= '0;
            blocked_q    <= 1'b0;
            blocked_id_q <= '0;
            lockout_q    <= '0;
            for (int k = 0; k < NREQ; k++) begin
                strike_q[k] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_any) begin
                        ptr_q <= gnt_idx;
                        if (sel_data == FORBIDDEN) begin
                            blocked_q    <= 1'b1;
                            blocked_id_q <= gnt_idx;
                            state_q      <= BLOCK;
                        end else begin
                            cmd_data_q <= sel_data;
                            cmd_stb_q  <= 1'b1;
                            state_q    <= SEND;
                        end
                    end
                end
                SEND: begin
                    if (!i_cmd_busy) begin
                        cmd_stb_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                BLOCK: begin
                    // Strike is committed on leaving BLOCK so a reset here drops it.
                    blocked_q              <= 1'b0;
                    strike_q[blocked_id_q] <= strike_d;
                    if (strike_d == STRIKE_MAX) begin
                        lockout_q[blocked_id_q] <= 1'b1;
                    end
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_cmd_stb    = cmd_stb_q;
    assign o_cmd_data   = cmd_data_q;
    assign o_blocked    = blocked_q;
    assign o_blocked_id = blocked_id_q;
    assign o_lockout    = lockout_q;

    a_no_forbidden: assert property (@(posedge i_clk) disable iff (i_reset)
        o_cmd_stb |-> (o_cmd_data != FORBIDDEN));

endmodule

// File: tb/tb_command_gatekeeper.sv
// Directed testbench for command_gatekeeper (NREQ=4, DW=32, LOCKOUT=3).
module tb_command_gatekeeper;

    localparam logic [31:0] FORBID = 32'hdeadbeef;

    logic         clk;
    logic         rst;
    logic [3:0]   req_stb;
    logic [127:0] req_data;
    logic [3:0]   req_busy;
    logic         cmd_stb;
    logic [31:0]  cmd_data;
    logic         cmd_busy;
    logic         blocked;
    logic [1:0]   blocked_id;
    logic [3:0]   lockout;

    int total = 0;
    int bad   = 0;

    command_gatekeeper #(
        .NREQ      (4),
        .DW        (32),
        .FORBIDDEN (FORBID),
        .LOCKOUT   (3)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_req_stb    (req_stb),
        .i_req_data   (req_data),
        .o_req_busy   (req_busy),
        .o_cmd_stb    (cmd_stb),
        .o_cmd_data   (cmd_data),
        .i_cmd_busy   (cmd_busy),
        .o_blocked    (blocked),
        .o_blocked_id (blocked_id),
        .o_lockout    (lockout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next falling edge; drive and sample there.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_data(input int k, input logic [31:0] d);
        req_data[k*32 +: 32] = d;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0]  eb;
        logic [31:0] ed;
        logic [3:0]  el;
        int          cnt [4];
        int          s;

        rst      = 1'b1;
        req_stb  = '0;
        req_data = '0;
        cmd_busy = 1'b0;

        // Reset state
        step();
        step();
        check("rst_cmd_stb", cmd_stb, 1'b0);
        check("rst_cmd_data", cmd_data, 32'h0);
        check("rst_blocked", blocked, 1'b0);
        check("rst_blocked_id", blocked_id, 2'd0);
        check("rst_lockout", lockout, 4'b0000);
        rst = 1'b0;
        settle();

        // 1: single requester, no backpressure
        set_data(0, 32'h12345678);
        req_stb = 4'b0001;
        settle();
        check("t1_busy", req_busy, 4'b1110);
        step();
        req_stb = 4'b0000;
        check("t1_stb", cmd_stb, 1'b1);
        check("t1_data", cmd_data, 32'h12345678);
        check("t1_blk", blocked, 1'b0);
        step();
        check("t1_stb_done", cmd_stb, 1'b0);
        check("t1_blk_done", blocked, 1'b0);

        // 2: backpressure holds the command stable for 6 cycles
        set_data(1, 32'h0badf00d);
        req_stb  = 4'b0010;
        cmd_busy = 1'b1;
        settle();
        check("t2_busy_idle", req_busy, 4'b1101);
        step();
        set_data(1, 32'h11111111);
        for (int c = 0; c < 5; c++) begin
            settle();
            check("t2_stb_hold", cmd_stb, 1'b1);
            check("t2_data_hold", cmd_data, 32'h0badf00d);
            check("t2_busy_send", req_busy, 4'b1111);
            step();
        end
        cmd_busy = 1'b0;
        req_stb  = 4'b0000;
        settle();
        check("t2_stb_last", cmd_stb, 1'b1);
        check("t2_data_last", cmd_data, 32'h0badf00d);
        step();
        check("t2_stb_done", cmd_stb, 1'b0);

        // Fresh pointer for the round-robin sequence
        rst = 1'b1;
        step();
        rst = 1'b0;
        settle();

        // 3: round-robin with all requesters strobing
        for (int k = 0; k < 4; k++) begin
            cnt[k] = 0;
            set_data(k, 32'hA000_0000 + 32'(k * 16));
        end
        req_stb = 4'b1111;
        settle();
        for (int g = 0; g < 8; g++) begin
            s  = g % 4;
            eb = ~(4'b0001 << s);
            check("t3_busy_idle", req_busy, eb);
            step();
            ed = 32'hA000_0000 + 32'(s * 16 + cnt[s]);
            check("t3_stb", cmd_stb, 1'b1);
            check("t3_data", cmd_data, ed);
            cnt[s]++;
            set_data(s, 32'hA000_0000 + 32'(s * 16 + cnt[s]));
            if (g == 7) req_stb = 4'b0000;
            settle();
            check("t3_busy_send", req_busy, 4'b1111);
            step();
        end
        check("t3_stb_done", cmd_stb, 1'b0);

        // 4: interlock on a FORBIDDEN command
        set_data(2, FORBID);
        req_stb = 4'b0100;
        settle();
        check("t4_busy", req_busy, 4'b1011);
        step();
        req_stb = 4'b0000;
        check("t4_blocked", blocked, 1'b1);
        check("t4_blocked_id", blocked_id, 2'd2);
        check("t4_stb", cmd_stb, 1'b0);
        step();
        check("t4_blocked_end", blocked, 1'b0);
        check("t4_stb_end", cmd_stb, 1'b0);
        check("t4_lockout", lockout, 4'b0000);
        check("t4_strike2", dut.strike_q[2], 2'd1);

        // 5: three strikes lock requester 3 out
        for (int n = 1; n <= 3; n++) begin
            set_data(3, FORBID);
            req_stb = 4'b1000;
            settle();
            check("t5_busy", req_busy, 4'b0111);
            step();
            req_stb = 4'b0000;
            check("t5_blocked", blocked, 1'b1);
            check("t5_blocked_id", blocked_id, 2'd3);
            check("t5_stb", cmd_stb, 1'b0);
            step();
            el = (n == 3) ? 4'b1000 : 4'b0000;
            check("t5_lockout", lockout, el);
            check("t5_blocked_end", blocked, 1'b0);
        end

        set_data(3, 32'h00000001);
        set_data(0, 32'h55550000);
        req_stb = 4'b1001;
        settle();
        check("t5_busy_mix", req_busy, 4'b0110);
        step();
        check("t5_data0a", cmd_data, 32'h55550000);
        check("t5_busy_send", req_busy, 4'b0111);
        set_data(0, 32'h55550001);
        step();
        check("t5_busy_mix2", req_busy, 4'b0110);
        step();
        check("t5_data0b", cmd_data, 32'h55550001);
        req_stb = 4'b1000;
        step();
        check("t5_stb_idle", cmd_stb, 1'b0);
        check("t5_busy_lock", req_busy, 4'b0111);
        check("t5_blk_idle", blocked, 1'b0);
        step();
        check("t5_stb_never", cmd_stb, 1'b0);
        req_stb = 4'b0000;

        // 6: reset during SEND
        set_data(1, 32'h77777777);
        req_stb  = 4'b0010;
        cmd_busy = 1'b1;
        step();
        req_stb = 4'b0000;
        check("t6_stb_pre", cmd_stb, 1'b1);
        check("t6_data_pre", cmd_data, 32'h77777777);
        rst = 1'b1;
        settle();
        check("t6_stb_async", cmd_stb, 1'b0);
        check("t6_data_async", cmd_data, 32'h0);
        check("t6_lockout", lockout, 4'b0000);
        check("t6_strike3", dut.strike_q[3], 2'd0);
        step();
        rst      = 1'b0;
        cmd_busy = 1'b0;
        for (int k = 0; k < 4; k++) set_data(k, 32'hC000_0000 + 32'(k));
        req_stb = 4'b1111;
        settle();
        check("t6_busy_first", req_busy, 4'b1110);
        step();
        req_stb = 4'b0000;
        check("t6_first_data", cmd_data, 32'hC000_0000);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
